// File: rtl/ahb_rr_arbiter.sv
// Round-robin AHB arbiter for up to 16 masters with locked-transfer hold,
// SPLIT masking, RETRY/SPLIT forced re-arbitration and default-master parking.
module ahb_rr_arbiter #(
  parameter int unsigned NUM_MASTERS    = 16,
  parameter int unsigned DEFAULT_MASTER = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [15:0] HBUSREQx,
  input  logic [15:0] HLOCKx,
  input  logic [15:0] HSPLIT,
  input  logic [1:0]  HRESP,
  input  logic        HREADY,
  output logic [15:0] HGRANTx,
  output logic [3:0]  HMASTER,
  output logic        HMASTLOCK
);

  typedef enum logic [1:0] {
    RESP_OKAY  = 2'b00,
    RESP_ERROR = 2'b01,
    RESP_RETRY = 2'b10,
    RESP_SPLIT = 2'b11
  } resp_e;

  localparam logic [3:0] DEF = 4'(DEFAULT_MASTER);

  resp_e       resp;
  logic [15:0] grant, grant_n;
  logic [3:0]  master, data_master, last_owner, last_owner_n, owner;
  logic        lock, resp_pend;
  logic [15:0] split_mask, split_mask_n;
  logic [15:0] valid, eligible, pick_mask;
  logic        rearb, arbitrate, found;
  logic [3:0]  winner;
  int unsigned idx;

  assign resp = resp_e'(HRESP);

  always_comb begin
    owner = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (grant[i]) owner = 4'(i);
    end
  end

  always_comb begin
    valid = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      valid[i] = (i < NUM_MASTERS);
    end
    eligible = HBUSREQx & ~split_mask & valid;
  end

  // Forced re-arbitration only on the first cycle of a two-cycle RETRY/SPLIT response.
  assign rearb     = ~HREADY & (resp == RESP_RETRY || resp == RESP_SPLIT) & ~resp_pend;
  assign arbitrate = rearb | (HREADY & ~HLOCKx[owner]);

  always_comb begin
    pick_mask = eligible;
    if (rearb) pick_mask[data_master] = 1'b0;
    found  = 1'b0;
    winner = DEF;
    idx    = 0;
    for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
      idx = 32'(last_owner) + k;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (!found && pick_mask[idx[3:0]]) begin
        found  = 1'b1;
        winner = idx[3:0];
      end
    end
  end

  always_comb begin
    grant_n      = grant;
    last_owner_n = last_owner;
    if (arbitrate) begin
      grant_n         = '0;
      grant_n[winner] = 1'b1;
      if (found) last_owner_n = winner;
    end
    split_mask_n = split_mask;
    if (rearb && resp == RESP_SPLIT && data_master != DEF) split_mask_n[data_master] = 1'b1;
    split_mask_n = split_mask_n & ~HSPLIT;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      grant            <= '0;
      grant[DEF]       <= 1'b1;
      master           <= DEF;
      lock             <= 1'b0;
      data_master      <= DEF;
      last_owner       <= DEF;
      split_mask       <= '0;
      resp_pend        <= 1'b0;
    end else begin
      grant      <= grant_n;
      last_owner <= last_owner_n;
      split_mask <= split_mask_n;
      resp_pend  <= ~HREADY & (resp_pend | HRESP[1]);
      if (HREADY) begin
        data_master <= master;
        master      <= owner;
        lock        <= HLOCKx[owner];
      end
    end
  end

  assign HGRANTx   = grant;
  assign HMASTER   = master;
  assign HMASTLOCK = lock;

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Self-checking bench for ahb_rr_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked against a behavioural model.
module tb_ahb_rr_arbiter;

  localparam int N   = 16;
  localparam int DEF = 0;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [15:0] HBUSREQx, HLOCKx, HSPLIT;
  logic [1:0]  HRESP;
  logic        HREADY;
  logic [15:0] HGRANTx;
  logic [3:0]  HMASTER;
  logic        HMASTLOCK;

  ahb_rr_arbiter #(.NUM_MASTERS(N), .DEFAULT_MASTER(DEF)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HBUSREQx(HBUSREQx), .HLOCKx(HLOCKx),
    .HSPLIT(HSPLIT), .HRESP(HRESP), .HREADY(HREADY), .HGRANTx(HGRANTx),
    .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK)
  );

  always #5 HCLK = ~HCLK;

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;
  bit live = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who holds the grant, who owns address/data phase.
  int        m_grant, m_master, m_data, m_last;
  bit        m_lock, m_pend;
  bit [15:0] m_split;
  int        wait_cnt[N];

  function automatic int rr_pick(input int excl);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (m_last + k) % N;
      if (HBUSREQx[i] && !m_split[i] && i != excl) return i;
    end
    return -1;
  endfunction

  always @(posedge HCLK) begin
    int w;
    bit first_retry;
    for (int i = 0; i < N; i++) begin
      if (!live || HRESET || !HBUSREQx[i] || HGRANTx[i]) wait_cnt[i] = 0;
      else if (HREADY) wait_cnt[i] = wait_cnt[i] + 1;
    end
    if (HRESET) begin
      m_grant = DEF; m_master = DEF; m_lock = 0; m_data = DEF;
      m_last = DEF; m_split = '0; m_pend = 0;
    end else begin
      first_retry = !HREADY && HRESP[1] && !m_pend;
      if (first_retry) begin
        w = rr_pick(m_data);
        if (HRESP == 2'b11 && m_data != DEF) m_split[m_data] = 1'b1;
        if (w >= 0) begin m_grant = w; m_last = w; end else m_grant = DEF;
      end else if (HREADY) begin
        int prev;
        prev = m_grant;
        if (!HLOCKx[prev]) begin
          w = rr_pick(-1);
          if (w >= 0) begin m_grant = w; m_last = w; end else m_grant = DEF;
        end
        m_data   = m_master;
        m_master = prev;
        m_lock   = HLOCKx[prev];
      end
      m_split = m_split & ~HSPLIT;
      m_pend  = HREADY ? 1'b0 : (m_pend | HRESP[1]);
    end
  end

  always @(negedge HCLK) begin
    if (chk_en) begin
      int mx;
      check("hgrant", HGRANTx, 32'(1) << m_grant);
      check("hmaster", HMASTER, m_master);
      check("hmastlock", HMASTLOCK, m_lock);
      check("onehot", $onehot(HGRANTx), 1);
      if (live) begin
        mx = 0;
        for (int i = 0; i < N; i++) if (wait_cnt[i] > mx) mx = wait_cnt[i];
        check("liveness_wait_le_16", mx <= 16, 1);
      end
    end
  end

  initial begin
    logic [15:0] gseq [4];
    logic [3:0]  mseq [4];
    bit          got;
    gseq = '{16'h0002, 16'h0004, 16'h0008, 16'h0002};
    mseq = '{4'd0, 4'd1, 4'd2, 4'd3};

    HRESET = 1; HREADY = 1; HRESP = 2'b00; HBUSREQx = '0; HLOCKx = '0; HSPLIT = '0;
    repeat (2) @(negedge HCLK);
    HRESET = 0;
    chk_en = 1;

    for (int i = 0; i < 20; i++) begin
      @(negedge HCLK);
      check("idle_grant", HGRANTx, 16'h0001);
      check("idle_master", HMASTER, 0);
      check("idle_lock", HMASTLOCK, 0);
    end

    HBUSREQx = 16'h000E;
    for (int i = 0; i < 4; i++) begin
      @(negedge HCLK);
      check("rr_grant", HGRANTx, gseq[i]);
      check("rr_master_lag", HMASTER, mseq[i]);
    end

    HBUSREQx = 16'h0109; HLOCKx = 16'h0008;
    @(negedge HCLK);
    check("lock_grant", HGRANTx, 16'h0008);
    for (int i = 0; i < 6; i++) begin
      @(negedge HCLK);
      check("lock_hold", HGRANTx, 16'h0008);
      check("lock_mastlock", HMASTLOCK, 1);
      check("lock_master", HMASTER, 3);
    end
    HLOCKx = '0;
    @(negedge HCLK);
    check("unlock_grant", HGRANTx, 16'h0100);
    check("unlock_master", HMASTER, 3);
    check("unlock_mastlock", HMASTLOCK, 0);

    HREADY = 0;
    for (int i = 0; i < 5; i++) begin
      HBUSREQx = 16'($urandom);
      @(negedge HCLK);
      check("stall_grant", HGRANTx, 16'h0100);
      check("stall_master", HMASTER, 3);
    end

    HREADY = 1; HBUSREQx = 16'h0004;
    @(negedge HCLK);
    check("post_stall_grant", HGRANTx, 16'h0004);
    check("post_stall_master", HMASTER, 8);
    repeat (2) @(negedge HCLK);
    check("pre_split_master", HMASTER, 2);

    HBUSREQx = 16'h0006; HREADY = 0; HRESP = 2'b11;
    @(negedge HCLK);
    check("split_regrant", HGRANTx, 16'h0002);
    HREADY = 1; HRESP = 2'b00;
    repeat (2) begin
      @(negedge HCLK);
      check("split_masked", HGRANTx, 16'h0002);
    end
    HSPLIT = 16'h0004;
    @(negedge HCLK);
    HSPLIT = '0;
    got = 0;
    for (int i = 0; i < N && !got; i++) begin
      @(negedge HCLK);
      if (HGRANTx == 16'h0004) got = 1;
    end
    check("split_resume_within_N", got, 1);

    for (int c = 0; c < 3000; c++) begin
      int r;
      @(negedge HCLK);
      HRESET   = ($urandom_range(0, 199) == 0);
      HREADY   = ($urandom_range(0, 3) != 0);
      r        = $urandom_range(0, 9);
      HRESP    = (r < 6) ? 2'b00 : (r < 7) ? 2'b01 : (r < 8) ? 2'b10 : 2'b11;
      HBUSREQx = 16'($urandom);
      HLOCKx   = 16'($urandom & $urandom & $urandom);
      HSPLIT   = ($urandom_range(0, 3) == 0) ? 16'($urandom & $urandom) : 16'h0000;
    end

    @(negedge HCLK);
    HRESET = 1; HLOCKx = '0; HRESP = 2'b00; HSPLIT = '0; HREADY = 1;
    @(negedge HCLK);
    HRESET = 0;
    live = 1;
    for (int c = 0; c < 2000; c++) begin
      @(negedge HCLK);
      HREADY   = ($urandom_range(0, 3) != 0);
      HBUSREQx = HBUSREQx ^ 16'($urandom & $urandom & $urandom);
    end
    @(negedge HCLK);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
